// File: rtl/add_exec_unit.sv
// Integer add/subtract unit for one Tomasulo add slot: one operation in flight,
// fixed latency, result broadcast on the CDB under a request/grant handshake.
module add_exec_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 3,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  issue_a,
    input  logic [XLEN-1:0]  issue_b,
    input  logic [6:0]       issue_fun7,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             busy,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_exc,
    input  logic             flush
);

    localparam logic [6:0] FUN7_ADD = 7'b0000000;
    localparam logic [6:0] FUN7_SUB = 7'b0100000;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CDB = 2'd2
    } state_t;

    // Returns {illegal_funct7, result}; unknown encodings still add.
    function automatic logic [XLEN:0] alu_f(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b,
                                             input logic [6:0]      f);
        logic [XLEN:0] r;
        case (f)
            FUN7_ADD: r = {1'b0, a + b};
            FUN7_SUB: r = {1'b0, a - b};
            default:  r = {1'b1, a + b};
        endcase
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic             load_s;
    logic [XLEN:0]    alu_res_s;
    logic             busy_r, cdb_req_r, cdb_exc_r;
    logic [TAG_W-1:0] cdb_tag_r;
    logic [XLEN-1:0]  cdb_data_r;

    assign alu_res_s = alu_f(issue_a, issue_b, issue_fun7);

    // Next-state logic; flush beats grant, grant beats issue.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        if (flush) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_valid) begin
                        load_s = 1'b1;
                        if (LATENCY == 1) begin
                            state_nxt_s = WAIT_CDB;
                            cnt_nxt_s   = 4'd0;
                        end else begin
                            state_nxt_s = EXEC;
                            cnt_nxt_s   = CNT_INIT;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = WAIT_CDB;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r - 4'd1;
                    end
                end
                WAIT_CDB: begin
                    if (cdb_grant) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_CDB;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs; the result is captured at issue and held until granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            cdb_req_r  <= 1'b0;
            cdb_exc_r  <= 1'b0;
            cdb_tag_r  <= {TAG_W{1'b0}};
            cdb_data_r <= {XLEN{1'b0}};
        end else begin
            busy_r    <= (state_nxt_s != IDLE);
            cdb_req_r <= (state_nxt_s == WAIT_CDB);
            if (load_s) begin
                cdb_exc_r  <= alu_res_s[XLEN];
                cdb_tag_r  <= issue_tag;
                cdb_data_r <= alu_res_s[XLEN-1:0];
            end
        end
    end

    assign busy     = busy_r;
    assign cdb_req  = cdb_req_r;
    assign cdb_exc  = cdb_exc_r;
    assign cdb_tag  = cdb_tag_r;
    assign cdb_data = cdb_data_r;

endmodule

// File: tb/tb_add_exec_unit.sv
// Scoreboard bench for add_exec_unit: directed issues push expected results,
// a negedge monitor pops and compares on every accepted CDB transfer.
module tb_add_exec_unit;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 3;
    localparam int LATENCY = 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic             exc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [XLEN-1:0]  issue_a, issue_b;
    logic [6:0]       issue_fun7;
    logic [TAG_W-1:0] issue_tag;
    logic             busy, cdb_req, cdb_grant, cdb_exc, flush;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    add_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_a(issue_a),
        .issue_b(issue_b), .issue_fun7(issue_fun7), .issue_tag(issue_tag),
        .busy(busy), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_exc(cdb_exc), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on req && grant without flush.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && cdb_req && cdb_grant && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cdb_unexpected actual tag=%0h data=%0h expected=none", cdb_tag, cdb_data);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                chk("cdb_data", 64'(cdb_data), 64'(e.data));
                chk("cdb_exc", 64'(cdb_exc), 64'(e.exc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [6:0] f, input logic [TAG_W-1:0] t);
        issue_valid = 1'b1;
        issue_a     = a;
        issue_b     = b;
        issue_fun7  = f;
        issue_tag   = t;
    endtask

    task automatic expect_res(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d, input logic x);
        exp_t e;
        e.tag  = t;
        e.data = d;
        e.exc  = x;
        exp_q.push_back(e);
    endtask

    // Issue with grant high, then change inputs to prove they were captured.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [6:0] f,
                          input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d, input logic x);
        cdb_grant = 1'b1;
        drive(a, b, f, t);
        expect_res(t, d, x);
        tick();
        issue_valid = 1'b0;
        issue_a     = 32'hDEAD_BEEF;
        issue_b     = 32'h1234_5678;
        issue_fun7  = 7'b0100000;
        chk("op_busy_c1", 64'(busy), 64'd1);
        chk("op_req_c1", 64'(cdb_req), 64'd0);
        tick();
        chk("op_req_c2", 64'(cdb_req), 64'd1);
        tick();
        chk("op_busy_c3", 64'(busy), 64'd0);
        chk("op_req_c3", 64'(cdb_req), 64'd0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_a = '0; issue_b = '0;
        issue_fun7 = 7'd0; issue_tag = 3'd0; cdb_grant = 1'b0; flush = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(cdb_req), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op(32'd5, 32'd7, 7'b0000000, 3'd3, 32'd12, 1'b0);
        run_op(32'd3, 32'd5, 7'b0100000, 3'd6, 32'hFFFF_FFFE, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 7'b0000000, 3'd2, 32'd0, 1'b0);
        run_op(32'd2, 32'd2, 7'b0000001, 3'd4, 32'd4, 1'b1);

        // Backpressure with an ignored second issue
        cdb_grant = 1'b0;
        drive(32'd10, 32'd20, 7'b0000000, 3'd1);
        expect_res(3'd1, 32'd30, 1'b0);
        tick();
        issue_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_req", 64'(cdb_req), 64'd1);
            chk("bp_tag", 64'(cdb_tag), 64'd1);
            chk("bp_data", 64'(cdb_data), 64'd30);
            chk("bp_busy", 64'(busy), 64'd1);
            if (i == 1) drive(32'd99, 32'd1, 7'b0000001, 3'd7);
            else        issue_valid = 1'b0;
            tick();
        end
        issue_valid = 1'b0;
        cdb_grant   = 1'b1;
        tick();
        chk("grant_busy", 64'(busy), 64'd0);
        chk("grant_req", 64'(cdb_req), 64'd0);
        drive(32'd1, 32'd1, 7'b0000000, 3'd2);
        expect_res(3'd2, 32'd2, 1'b0);
        tick();
        issue_valid = 1'b0;
        chk("reissue_busy", 64'(busy), 64'd1);
        tick();
        tick();
        chk("reissue_done", 64'(busy), 64'd0);

        // Flush during EXEC: op must never reach the CDB
        drive(32'd4, 32'd4, 7'b0000000, 3'd5);
        tick();
        issue_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_exec_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_exec_req", 64'(cdb_req), 64'd0);
            tick();
        end

        // Flush together with grant in WAIT_CDB
        cdb_grant = 1'b0;
        drive(32'd8, 32'd8, 7'b0000000, 3'd7);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("flush_wait_req", 64'(cdb_req), 64'd1);
        flush = 1'b1;
        cdb_grant = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_wait_busy", 64'(busy), 64'd0);
        chk("flush_wait_req0", 64'(cdb_req), 64'd0);

        // Flush with issue in IDLE drops the issue
        drive(32'd1, 32'd2, 7'b0000000, 3'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);

        // Async reset while waiting for the CDB
        cdb_grant = 1'b0;
        drive(32'd6, 32'd6, 7'b0100001, 3'd6);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("pre_rst_req", 64'(cdb_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_req", 64'(cdb_req), 64'd0);
        chk("arst_tag", 64'(cdb_tag), 64'd0);
        chk("arst_data", 64'(cdb_data), 64'd0);
        chk("arst_exc", 64'(cdb_exc), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
